shift_serializer_lr: RTL and testbench

- Parallel-to-serial transmitter that drives the serial input and direction select of the team's left/right shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake, then emits it one bit per clock.
- Bit order is chosen per word so that, after WIDTH shifts, the downstream register holds the word in natural bit order.
- Sits between a parallel data source and shift_register_left_right (ser_out drives `in`, sel_out drives `sel`).

---
 rtl/shift_serializer_lr.sv | 231 +++++++++++++++++++++++
 tb/tb_shift_serializer_lr.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer_lr.sv
// shift_serializer_lr
//
// Parallel-to-serial transmitter feeding shift_register_left_right.
// A WIDTH-bit word is taken over a valid/ready handshake and then sent one
// bit per clock on ser_out, with sel_out giving the shift direction so that
// the downstream register ends up holding the word in natural bit order.
//
// Handshake: a word is accepted on a rising Clk edge where valid_in = 1 and
// ready_out = 1. valid_in seen while ready_out = 0 is ignored (nothing is
// buffered), and data_in/dir_in are only sampled on the accepting edge.
//
// Parameters:
//   WIDTH - data word width in bits (>= 2)
//   GAP   - idle cycles after each frame before ready_out reasserts (0..15)
//
// Optional feature (compile-time macro SHIFT_SERIALIZER_PARITY_EN):
//   appends one even-parity bit to every frame; done_out then marks the
//   parity bit instead of the last data bit.
//
// Ports:
//   Clk        in   rising-edge system clock
//   Rst_n      in   asynchronous active-low reset
//   data_in    in   parallel word to send
//   dir_in     in   1 = right shift (LSB first), 0 = left shift (MSB first)
//   valid_in   in   source has a word on data_in/dir_in
//   ready_out  out  block can accept a word
//   ser_out    out  serial data bit (0 whenever valid_out = 0)
//   sel_out    out  direction select, held for the whole frame and while idle
//   valid_out  out  ser_out carries a frame bit this cycle
//   done_out   out  one-cycle pulse on the final frame bit
//   state_dbg  out  current FSM state (0 IDLE, 1 SHIFT, 2 GAP, 3 PARITY)
//
// All outputs are registered.

module shift_serializer_lr #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             sel_out,
    output logic             valid_out,
    output logic             done_out,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);
    localparam logic [3:0]    GAP_LAST     = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2
`ifdef SHIFT_SERIALIZER_PARITY_EN
        ,
        S_PARITY = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             ready_q, ready_d;
    logic             ser_q, ser_d;
    logic             sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic accept;

    // ready_q is the registered ready_out, so the handshake uses exactly
    // what the source sees.
    assign accept = (state_q == S_IDLE) && valid_in && ready_q;

    // ------------------------------------------------------------------
    // State register and all output/datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b0;
            ser_q     <= 1'b0;
            sel_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ready_q   <= ready_d;
            ser_q     <= ser_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // state_q names what the registered outputs are showing right now;
    // in SHIFT, cnt_q is the index of the bit currently on ser_out.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
`endif
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                state_d = (GAP > 0) ? S_GAP : S_IDLE;
            end
`endif
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        sel_d     = sel_q;
        ready_d   = 1'b0;
        ser_d     = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    // The first bit goes straight to ser_out on the accept
                    // edge; the buffer keeps the remaining bits pre-shifted
                    // so the next bit always sits at the outgoing end.
                    ready_d = 1'b0;
                    sel_d   = dir_in;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    ser_d   = dir_in ? data_in[0] : data_in[WIDTH-1];
                    buf_d   = dir_in ? (data_in >> 1) : (data_in << 1);
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            S_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    ser_d   = sel_q ? buf_q[0] : buf_q[WIDTH-1];
                    buf_d   = sel_q ? (buf_q >> 1) : (buf_q << 1);
`ifndef SHIFT_SERIALIZER_PARITY_EN
                    done_d  = (cnt_q == CNT_PRE_LAST);
`endif
                end else begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    valid_d = 1'b1;
                    ser_d   = parity_q;
                    done_d  = 1'b1;
`else
                    gap_cnt_d = '0;
                    ready_d   = (GAP == 0);
`endif
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                gap_cnt_d = '0;
                ready_d   = (GAP == 0);
            end
`endif
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    assign ready_out = ready_q;
    assign ser_out   = ser_q;
    assign sel_out   = sel_q;
    assign valid_out = valid_q;
    assign done_out  = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_serializer_lr.sv
// Testbench for shift_serializer_lr.
// Two instances share the stimulus: one with GAP = 0 and one with GAP = 2.
// A frame-level reference model turns every accepted word into the list of
// per-cycle output tuples it must produce; a monitor compares every cycle.

module tb_shift_serializer_lr;

    localparam int W     = 4;
    localparam int GAP_B = 2;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic [W-1:0] data_in;
    logic         dir_in;
    logic         valid_in;

    logic       ready0, ser0, sel0, valid0, done0;
    logic       ready1, ser1, sel1, valid1, done1;
    logic [1:0] st0, st1;

    shift_serializer_lr #(.WIDTH(W), .GAP(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .data_in(data_in), .dir_in(dir_in),
        .valid_in(valid_in), .ready_out(ready0), .ser_out(ser0),
        .sel_out(sel0), .valid_out(valid0), .done_out(done0),
        .state_dbg(st0)
    );

    shift_serializer_lr #(.WIDTH(W), .GAP(GAP_B)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .data_in(data_in), .dir_in(dir_in),
        .valid_in(valid_in), .ready_out(ready1), .ser_out(ser1),
        .sel_out(sel1), .valid_out(valid1), .done_out(done1),
        .state_dbg(st1)
    );

    // Tuple layout: {ready, valid, ser, sel, done}
    logic [4:0] obs [2];
    assign obs[0] = {ready0, valid0, ser0, sel0, done0};
    assign obs[1] = {ready1, valid1, ser1, sel1, done1};

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [4:0] exp_q [2][$];
    logic [4:0] cur [2];

    // Reference model: a word is taken whenever the expected ready is high
    // and valid_in is set; it expands into W data cycles (plus the parity
    // cycle), then GAP idle-not-ready cycles. With nothing queued the block
    // is idle and ready, keeping its last direction select.
    initial begin
        cur[0] = '0;
        cur[1] = '0;
        forever begin
            @(posedge Clk or negedge Rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!Rst_n) begin
                    exp_q[i].delete();
                    cur[i] = '0;
                end else begin
                    if (cur[i][4] && valid_in) begin
                        int g;
                        logic b;
                        g = (i == 0) ? 0 : GAP_B;
                        for (int k = 0; k < W; k++) begin
                            b = dir_in ? data_in[k] : data_in[W-1-k];
                            exp_q[i].push_back({1'b0, 1'b1, b, dir_in, (k == W-1) && !PAR});
                        end
                        if (PAR) exp_q[i].push_back({1'b0, 1'b1, ^data_in, dir_in, 1'b1});
                        for (int j = 0; j < g; j++)
                            exp_q[i].push_back({1'b0, 1'b0, 1'b0, dir_in, 1'b0});
                    end
                    if (exp_q[i].size() > 0) cur[i] = exp_q[i].pop_front();
                    else cur[i] = {1'b1, 1'b0, 1'b0, cur[i][1], 1'b0};
                end
            end
        end
    end

    // Monitor: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge Clk);
            check("dut0_outputs", {27'd0, obs[0]}, {27'd0, cur[0]});
            check("dut1_outputs", {27'd0, obs[1]}, {27'd0, cur[1]});
        end
    end

    // Downstream shift_register_left_right behaviour, fed by dut0.
    logic [W-1:0] sr = '0;
    initial begin
        forever begin
            @(posedge Clk);
            if (valid0) sr = sel0 ? {ser0, sr[W-1:1]} : {sr[W-2:0], ser0};
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_reset(input int cycles);
        Rst_n    = 1'b0;
        valid_in = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_outputs0", {27'd0, obs[0]}, 32'd0);
        check("rst_outputs1", {27'd0, obs[1]}, 32'd0);
        check("rst_state", {30'd0, st0}, 32'd0);
        repeat (cycles - 1) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("ready_after_rst", {31'd0, ready0}, 32'd1);
    endtask

    task automatic wait_ready0();
        int t;
        t = 0;
        while (ready0 !== 1'b1) begin
            @(posedge Clk);
            #1;
            t++;
            if (t > 200) begin
                check("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    // Returns one cycle after the accept edge, with the first bit showing.
    task automatic send_word(input logic [W-1:0] d, input logic dir);
        wait_ready0();
        data_in  = d;
        dir_in   = dir;
        valid_in = 1'b1;
        @(posedge Clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [W-1:0] seq;

    initial begin
        data_in  = '0;
        dir_in   = 1'b0;
        valid_in = 1'b0;

        // Reset held 3 cycles.
        do_reset(3);

        // 1011, right shift: LSB first.
        seq = 4'b1011;
        send_word(seq, 1'b1);
        for (int k = 0; k < W; k++) begin
            check("t2_ser", {31'd0, ser0}, {31'd0, seq[k]});
            check("t2_valid", {31'd0, valid0}, 32'd1);
            check("t2_sel", {31'd0, sel0}, 32'd1);
            check("t2_done", {31'd0, done0}, {31'd0, (k == W-1) && !PAR});
            next_cycle();
        end
        check("t2_sr", {28'd0, sr}, {28'd0, seq});

        // 1011, left shift: MSB first.
        send_word(seq, 1'b0);
        for (int k = 0; k < W; k++) begin
            check("t3_ser", {31'd0, ser0}, {31'd0, seq[W-1-k]});
            check("t3_sel", {31'd0, sel0}, 32'd0);
            next_cycle();
        end
        check("t3_sr", {28'd0, sr}, {28'd0, seq});

        // New word offered mid-frame and held until accepted.
        send_word(seq, 1'b1);
        for (int k = 0; k < W; k++) begin
            if (k == 1) begin
                data_in  = 4'b0000;
                dir_in   = 1'b0;
                valid_in = 1'b1;
            end
            check("t4_ser", {31'd0, ser0}, {31'd0, seq[k]});
            check("t4_sel", {31'd0, sel0}, 32'd1);
            next_cycle();
        end
        wait_ready0();
        next_cycle();
        valid_in = 1'b0;
        check("t4_new_valid", {31'd0, valid0}, 32'd1);
        check("t4_new_ser", {31'd0, ser0}, 32'd0);
        check("t4_new_sel", {31'd0, sel0}, 32'd0);

        // Reset during bit 2.
        send_word(seq, 1'b1);
        next_cycle();
        #1;
        Rst_n = 1'b0;
        #1;
        check("t5_valid", {31'd0, valid0}, 32'd0);
        check("t5_ser", {31'd0, ser0}, 32'd0);
        check("t5_done", {31'd0, done0}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        seq = 4'b0110;
        send_word(seq, 1'b1);
        for (int k = 0; k < W; k++) begin
            check("t5_ser_after", {31'd0, ser0}, {31'd0, seq[k]});
            next_cycle();
        end

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 600; n++) begin
            valid_in = ($urandom_range(0, 2) != 0);
            data_in  = W'($urandom);
            dir_in   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) begin
                #1;
                Rst_n = 1'b0;
                #1;
                check("rnd_rst_valid0", {31'd0, valid0}, 32'd0);
                check("rnd_rst_valid1", {31'd0, valid1}, 32'd0);
                #1;
                Rst_n = 1'b1;
            end
            next_cycle();
        end

        valid_in = 1'b0;
        repeat (12) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
